// File: rtl/shift_sequencer.sv
// Multi-cycle 32-bit shifter: applies one barrel stage (1,2,4,8,16) per cycle
// through a shared stage datapath, with valid/ready handshakes on both sides.
module shift_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  input  logic [5:0]  Signal,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] dataOut,
  output logic        op_err,
  output logic        busy
);

  localparam int unsigned DataWidth  = 32;
  localparam int unsigned ShamtWidth = 5;
  localparam int unsigned StageWidth = 3;
  localparam int unsigned FuncWidth  = 6;

  localparam logic [FuncWidth-1:0]  SLL       = 6'b000000;
  localparam logic [FuncWidth-1:0]  SRL       = 6'b000010;
  localparam logic [FuncWidth-1:0]  SRA       = 6'b000011;
  localparam logic [StageWidth-1:0] LastStage = 3'd4;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} stateE;

  stateE                  state, stateNext;
  logic [DataWidth-1:0]   dataReg, dataNext;
  logic [ShamtWidth-1:0]  shamtReg, shamtNext;
  logic [FuncWidth-1:0]   opReg, opNext;
  logic [StageWidth-1:0]  stageReg, stageNext;
  logic                   errReg, errNext;
  logic [ShamtWidth-1:0]  stepAmt;
  logic [DataWidth-1:0]   stepResult;
  logic                   opSupported;

  // Only the low shift-amount bits matter; upper bits are intentionally dropped.
  logic unusedDataB;
  assign unusedDataB = ^dataB[DataWidth-1:ShamtWidth];

  assign opSupported = (Signal == SLL) || (Signal == SRL) || (Signal == SRA);

  // Shared stage datapath: shift by 2^stage when that shamt bit is set.
  always_comb begin
    stepAmt    = ShamtWidth'(5'd1 << stageReg);
    stepResult = dataReg;
    if (shamtReg[stageReg]) begin
      unique case (opReg)
        SLL:     stepResult = dataReg << stepAmt;
        SRL:     stepResult = dataReg >> stepAmt;
        default: stepResult = DataWidth'($signed(dataReg) >>> stepAmt);
      endcase
    end
  end

  always_comb begin
    stateNext = state;
    dataNext  = dataReg;
    shamtNext = shamtReg;
    opNext    = opReg;
    stageNext = stageReg;
    errNext   = errReg;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          dataNext  = dataA;
          shamtNext = dataB[ShamtWidth-1:0];
          opNext    = Signal;
          stageNext = '0;
          errNext   = !opSupported;
          stateNext = opSupported ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        dataNext = stepResult;
        if (stageReg == LastStage) begin
          stageNext = '0;
          stateNext = DONE;
        end else begin
          stageNext = stageReg + StageWidth'(1);
        end
      end
      DONE: begin
        if (out_valid && out_ready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      dataReg  <= '0;
      shamtReg <= '0;
      opReg    <= '0;
      stageReg <= '0;
      errReg   <= 1'b0;
    end else begin
      state    <= stateNext;
      dataReg  <= dataNext;
      shamtReg <= shamtNext;
      opReg    <= opNext;
      stageReg <= stageNext;
      errReg   <= errNext;
    end
  end

  // Registered outputs; the result is captured on the first DONE cycle and held.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      dataOut   <= '0;
      op_err    <= 1'b0;
    end else begin
      in_ready <= (stateNext == IDLE);
      busy     <= (stateNext != IDLE);
      if (state == DONE && !out_valid) begin
        out_valid <= 1'b1;
        dataOut   <= dataReg;
        op_err    <= errReg;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
